uart_rx_fifo: RTL and testbench

Parametrised UART receiver that generalises the fixed 8N1 receiver. It supports 5–9 data bits, none/even/odd parity and 16× oversampling with majority voting. It detects framing errors, parity errors and break conditions, and buffers received characters with their status in a FIFO behind a valid/ready stream interface. It sits between the board RxD pin and any byte-consuming logic (command parsers, packet assemblers).

---
 rtl/uart_rx_fifo_pkg.sv | 30 +++
 rtl/uart_rx_fifo_tick_gen.sv | 43 ++++
 rtl/uart_rx_fifo.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path: parity modes, receiver states
// and a constant log2 helper used to size counters and pointers.
package uart_pkg;

    localparam int PAR_NONE = 32'sd0;
    localparam int PAR_EVEN = 32'sd1;
    localparam int PAR_ODD  = 32'sd2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_e;

    function automatic int clog2_f(input longint value);
        int     result;
        longint rem;
        result = 32'sd0;
        rem    = value - 64'sd1;
        while (rem > 64'sd0) begin
            result = result + 32'sd1;
            rem    = rem >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_tick_gen.sv
// Phase-accumulator tick generator: one-clk pulse at Baud*Oversampling on average,
// jitter limited to a single clk, so the error never accumulates across a character.
module uart_tick_gen
    import uart_pkg::*;
#(
    parameter int ClkFrequency = 48000000,
    parameter int Baud         = 115200,
    parameter int Oversampling = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam longint INC = longint'(Baud) * longint'(Oversampling);
    localparam longint LIM = longint'(ClkFrequency);
    localparam int     AW  = clog2_f(LIM + INC) + 32'sd1;

    localparam logic [AW-1:0] INC_V = AW'(INC);
    localparam logic [AW-1:0] LIM_V = AW'(LIM);

    logic [AW-1:0] acc_r;
    logic [AW-1:0] acc_sum_s;
    logic          tick_r;

    assign acc_sum_s = acc_r + INC_V;
    assign tick      = tick_r;

    // accumulator wraps modulo the clock frequency, pulsing on each wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r  <= '0;
            tick_r <= 1'b0;
        end else if (acc_sum_s >= LIM_V) begin
            acc_r  <= acc_sum_s - LIM_V;
            tick_r <= 1'b1;
        end else begin
            acc_r  <= acc_sum_s;
            tick_r <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver (5..9 data bits, optional parity, 16x oversampling
// with 3-sample majority) feeding a status-tagged FIFO behind a valid/ready port.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int ClkFrequency = 48000000,
    parameter int Baud         = 115200,
    parameter int DataBits     = 8,
    parameter int Parity       = 0,
    parameter int FifoDepth    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                RxD,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DataBits-1:0] m_data,
    output logic                m_perr,
    output logic                m_ferr,
    output logic                m_brk,
    output logic                overflow,
    input  logic                clr_ovf,
    output logic                rx_busy
);

    localparam int         EW       = DataBits + 32'sd3;
    localparam int         PW       = clog2_f(longint'(FifoDepth));
    localparam logic [3:0] LAST_BIT = 4'(DataBits - 32'sd1);
    localparam logic       HAS_PAR  = (Parity != PAR_NONE);
    localparam logic       ODD_PAR  = (Parity == PAR_ODD);

    if (ClkFrequency < Baud * 32'sd16) begin : g_bad_clk
        $error("uart_rx_fifo: ClkFrequency must be at least 16*Baud");
    end
    if (DataBits < 32'sd5 || DataBits > 32'sd9) begin : g_bad_bits
        $error("uart_rx_fifo: DataBits must be 5..9");
    end
    if (Parity < PAR_NONE || Parity > PAR_ODD) begin : g_bad_par
        $error("uart_rx_fifo: Parity must be 0, 1 or 2");
    end
    if (FifoDepth < 32'sd2 || (FifoDepth & (FifoDepth - 32'sd1)) != 32'sd0) begin : g_bad_depth
        $error("uart_rx_fifo: FifoDepth must be a power of two >= 2");
    end

    logic [1:0]          sync_r;
    logic                rx_s;
    logic                tick_s;
    logic [3:0]          cnt_r;
    logic                s7_r;
    logic                s8_r;
    logic                sample_pt_s;
    logic                bit_s;
    rx_state_e           state_r;
    rx_state_e           state_next_s;
    logic                start_det_s;
    logic                shift_en_s;
    logic                par_en_s;
    logic                stop_en_s;
    logic [DataBits-1:0] shift_r;
    logic [3:0]          bit_idx_r;
    logic                par_r;
    logic                perr_s;
    logic                ferr_s;
    logic                brk_s;
    logic                push_r;
    logic [EW-1:0]       push_entry_r;
    logic                rx_busy_r;

    logic [EW-1:0]       mem_r [FifoDepth];
    logic [PW:0]         wr_ptr_r;
    logic [PW:0]         rd_ptr_r;
    logic [PW:0]         wr_next_s;
    logic [PW:0]         rd_next_s;
    logic                full_s;
    logic                pop_s;
    logic                push_ok_s;
    logic [EW-1:0]       head_s;
    logic [EW-1:0]       head_r;
    logic                m_valid_r;
    logic                overflow_r;

    uart_tick_gen #(
        .ClkFrequency (ClkFrequency),
        .Baud         (Baud),
        .Oversampling (32'sd16)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    // two-flop synchronizer for the asynchronous line, idling high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], RxD};
        end
    end

    assign rx_s        = sync_r[1];
    assign sample_pt_s = tick_s && (cnt_r == 4'd9);
    assign bit_s       = (s7_r & s8_r) | (s7_r & rx_s) | (s8_r & rx_s);
    assign perr_s      = HAS_PAR && (((^shift_r) ^ par_r) != ODD_PAR);
    assign ferr_s      = ~bit_s;
    assign brk_s       = ferr_s && (shift_r == '0) && (!HAS_PAR || !par_r);

    // receiver state register; rx_busy follows the next state so it tracks state_r
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            rx_busy_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            rx_busy_r <= (state_next_s != IDLE);
        end
    end

    // next-state and datapath strobes
    always_comb begin
        state_next_s = state_r;
        start_det_s  = 1'b0;
        shift_en_s   = 1'b0;
        par_en_s     = 1'b0;
        stop_en_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (!rx_s) begin
                    state_next_s = START;
                    start_det_s  = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (sample_pt_s) begin
                    if (bit_s) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = DATA;
                    end
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (sample_pt_s) begin
                    shift_en_s = 1'b1;
                    if (bit_idx_r == LAST_BIT) begin
                        if (HAS_PAR) begin
                            state_next_s = PARITY;
                        end else begin
                            state_next_s = STOP;
                        end
                    end else begin
                        state_next_s = DATA;
                    end
                end else begin
                    state_next_s = DATA;
                end
            end
            PARITY: begin
                if (sample_pt_s) begin
                    par_en_s     = 1'b1;
                    state_next_s = STOP;
                end else begin
                    state_next_s = PARITY;
                end
            end
            STOP: begin
                if (sample_pt_s) begin
                    stop_en_s = 1'b1;
                    if (bit_s) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = WAIT_HIGH;
                    end
                end else begin
                    state_next_s = STOP;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_HIGH;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // oversample counter, majority samples, shift register and staged push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r        <= 4'd0;
            s7_r         <= 1'b1;
            s8_r         <= 1'b1;
            shift_r      <= '0;
            bit_idx_r    <= 4'd0;
            par_r        <= 1'b0;
            push_r       <= 1'b0;
            push_entry_r <= '0;
        end else begin
            push_r <= stop_en_s;
            if (start_det_s) begin
                cnt_r <= 4'd0;
            end else if (tick_s) begin
                cnt_r <= cnt_r + 4'd1;
            end
            if (tick_s && cnt_r == 4'd7) begin
                s7_r <= rx_s;
            end
            if (tick_s && cnt_r == 4'd8) begin
                s8_r <= rx_s;
            end
            if (start_det_s) begin
                bit_idx_r <= 4'd0;
            end else if (shift_en_s) begin
                shift_r   <= {bit_s, shift_r[DataBits-1:1]};
                bit_idx_r <= bit_idx_r + 4'd1;
            end
            if (par_en_s) begin
                par_r <= bit_s;
            end
            if (stop_en_s) begin
                push_entry_r <= {brk_s, ferr_s, perr_s, shift_r};
            end
        end
    end

    assign full_s    = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
    assign pop_s     = m_valid_r & m_ready;
    assign push_ok_s = push_r && (!full_s || pop_s);
    assign wr_next_s = wr_ptr_r + (PW+1)'(push_ok_s);
    assign rd_next_s = rd_ptr_r + (PW+1)'(pop_s);

    // next head entry; a push into an otherwise-empty FIFO is forwarded to the output register
    always_comb begin
        head_s = mem_r[rd_next_s[PW-1:0]];
        if (push_ok_s && (wr_ptr_r[PW-1:0] == rd_next_s[PW-1:0])) begin
            head_s = push_entry_r;
        end else begin
            head_s = mem_r[rd_next_s[PW-1:0]];
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[PW-1:0]] <= push_entry_r;
        end
    end

    // pointers, registered head and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            m_valid_r  <= 1'b0;
            head_r     <= '0;
            overflow_r <= 1'b0;
        end else begin
            wr_ptr_r  <= wr_next_s;
            rd_ptr_r  <= rd_next_s;
            m_valid_r <= (wr_next_s != rd_next_s);
            if (wr_next_s != rd_next_s) begin
                head_r <= head_s;
            end
            if (push_r && full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end else if (clr_ovf) begin
                overflow_r <= 1'b0;
            end
        end
    end

    assign m_valid  = m_valid_r;
    assign m_data   = head_r[DataBits-1:0];
    assign m_perr   = head_r[DataBits];
    assign m_ferr   = head_r[DataBits+1];
    assign m_brk    = head_r[DataBits+2];
    assign overflow = overflow_r;
    assign rx_busy  = rx_busy_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench: an 8N1 depth-4 receiver and a 7O1 depth-4 receiver driven with directed
// and random frames; expected entries come from a frame-level reference model.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd_a, ready_a, clr_a, valid_a, perr_a, ferr_a, brk_a, ovf_a, busy_a;
    logic [7:0] data_a;
    logic       rxd_b, ready_b, clr_b, valid_b, perr_b, ferr_b, brk_b, ovf_b, busy_b;
    logic [6:0] data_b;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] exp_a[$];
    logic [15:0] obs_a[$];
    logic [15:0] exp_b[$];
    logic [15:0] obs_b[$];

    always #5 clk = ~clk;

    uart_rx_fifo #(.ClkFrequency(3200000), .Baud(100000), .DataBits(8), .Parity(0), .FifoDepth(4)) dut_a (
        .clk(clk), .rst(rst), .RxD(rxd_a), .m_valid(valid_a), .m_ready(ready_a), .m_data(data_a),
        .m_perr(perr_a), .m_ferr(ferr_a), .m_brk(brk_a), .overflow(ovf_a), .clr_ovf(clr_a), .rx_busy(busy_a)
    );

    uart_rx_fifo #(.ClkFrequency(3200000), .Baud(100000), .DataBits(7), .Parity(2), .FifoDepth(4)) dut_b (
        .clk(clk), .rst(rst), .RxD(rxd_b), .m_valid(valid_b), .m_ready(ready_b), .m_data(data_b),
        .m_perr(perr_b), .m_ferr(ferr_b), .m_brk(brk_b), .overflow(ovf_b), .clr_ovf(clr_b), .rx_busy(busy_b)
    );

    // record every accepted entry as {brk, ferr, perr, data}
    always @(posedge clk) begin
        if (valid_a && ready_a) obs_a.push_back(16'({brk_a, ferr_a, perr_a, data_a}));
        if (valid_b && ready_b) obs_b.push_back(16'({brk_b, ferr_b, perr_b, data_b}));
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // expected FIFO entry for one frame, from the line-level rules
    function automatic logic [15:0] model(input logic [8:0] d, input int nbits, input int pmode,
                                          input logic p, input logic stop);
        int   ones;
        logic perr, ferr, brk;
        ones = $countones(d);
        perr = 1'b0;
        if (pmode == 1) perr = ((ones + int'(p)) % 2) == 1;
        if (pmode == 2) perr = ((ones + int'(p)) % 2) == 0;
        ferr = !stop;
        brk  = ferr && (d == 9'd0) && (pmode == 0 || p == 1'b0);
        return 16'(d) | (16'(perr) << nbits) | (16'(ferr) << (nbits + 1)) | (16'(brk) << (nbits + 2));
    endfunction

    task automatic send(input int sel, input logic [8:0] d, input int nbits, input int hasp,
                        input logic p, input logic stop);
        logic [15:0] f;
        int          n;
        f = 16'(d) << 1;
        n = nbits + 1;
        if (hasp != 0) begin
            f[n] = p;
            n++;
        end
        f[n] = stop;
        n++;
        for (int i = 0; i < n; i++) begin
            if (sel == 0) rxd_a = f[i];
            else          rxd_b = f[i];
            repeat (32) @(negedge clk);
        end
    endtask

    task automatic compare_queue(input int sel, input string tag);
        if (sel == 0) begin
            check({tag, "_count"}, 16'(obs_a.size()), 16'(exp_a.size()));
            while (obs_a.size() > 0 && exp_a.size() > 0) check(tag, obs_a.pop_front(), exp_a.pop_front());
            obs_a.delete();
            exp_a.delete();
        end else begin
            check({tag, "_count"}, 16'(obs_b.size()), 16'(exp_b.size()));
            while (obs_b.size() > 0 && exp_b.size() > 0) check(tag, obs_b.pop_front(), exp_b.pop_front());
            obs_b.delete();
            exp_b.delete();
        end
    endtask

    initial begin
        logic [8:0] d;
        logic       p;
        int         model_depth;
        logic       model_ovf;

        rst = 1'b1; rxd_a = 1'b1; rxd_b = 1'b1;
        ready_a = 1'b1; ready_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_a", 16'({valid_a, ovf_a, busy_a, brk_a, ferr_a, perr_a, data_a}), 16'h0000);
        check("reset_b", 16'({valid_b, ovf_b, busy_b, brk_b, ferr_b, perr_b, data_b}), 16'h0000);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // back-to-back 8N1
        send(0, 9'h0A5, 8, 0, 1'b0, 1'b1); exp_a.push_back(model(9'h0A5, 8, 0, 1'b0, 1'b1));
        send(0, 9'h03C, 8, 0, 1'b0, 1'b1); exp_a.push_back(model(9'h03C, 8, 0, 1'b0, 1'b1));
        repeat (64) @(negedge clk);
        compare_queue(0, "8n1");
        check("8n1_ovf", 16'(ovf_a), 16'h0000);

        // 7O1 good then bad parity
        send(1, 9'h041, 7, 1, 1'b1, 1'b1); exp_b.push_back(model(9'h041, 7, 2, 1'b1, 1'b1));
        send(1, 9'h041, 7, 1, 1'b0, 1'b1); exp_b.push_back(model(9'h041, 7, 2, 1'b0, 1'b1));
        repeat (64) @(negedge clk);
        compare_queue(1, "odd_par");

        for (int i = 0; i < 8; i++) begin
            d = 9'($urandom_range(0, 127));
            p = 1'($urandom_range(0, 1));
            send(1, d, 7, 1, p, 1'b1);
            exp_b.push_back(model(d, 7, 2, p, 1'b1));
        end
        repeat (64) @(negedge clk);
        compare_queue(1, "rand_7o1");

        for (int i = 0; i < 8; i++) begin
            d = 9'($urandom_range(0, 255));
            send(0, d, 8, 0, 1'b0, 1'b1);
            exp_a.push_back(model(d, 8, 0, 1'b0, 1'b1));
        end
        repeat (64) @(negedge clk);
        compare_queue(0, "rand_8n1");

        // break: 20 bit times low
        rxd_a = 1'b0;
        repeat (20 * 32) @(negedge clk);
        check("brk_busy_hi", 16'(busy_a), 16'h0001);
        exp_a.push_back(model(9'h000, 8, 0, 1'b0, 1'b0));
        rxd_a = 1'b1;
        repeat (8) @(negedge clk);
        check("brk_busy_lo", 16'(busy_a), 16'h0000);
        repeat (64) @(negedge clk);
        compare_queue(0, "break");

        // 8-clk glitch
        rxd_a = 1'b0;
        repeat (5) @(negedge clk);
        check("glitch_busy_hi", 16'(busy_a), 16'h0001);
        repeat (3) @(negedge clk);
        rxd_a = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_busy_lo", 16'(busy_a), 16'h0000);
        repeat (64) @(negedge clk);
        compare_queue(0, "glitch");

        // overflow with the consumer stalled
        ready_a = 1'b0;
        model_depth = 0;
        model_ovf = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            d = 9'(i);
            send(0, d, 8, 0, 1'b0, 1'b1);
            if (model_depth < 4) begin
                exp_a.push_back(model(d, 8, 0, 1'b0, 1'b1));
                model_depth++;
            end else begin
                model_ovf = 1'b1;
            end
        end
        repeat (64) @(negedge clk);
        check("ovf_valid", 16'(valid_a), 16'h0001);
        check("ovf_set", 16'(ovf_a), 16'(model_ovf));
        check("ovf_head", 16'(data_a), 16'h0001);
        repeat (10) @(negedge clk);
        check("ovf_head_stable", 16'(data_a), 16'h0001);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        @(negedge clk);
        check("ovf_cleared", 16'(ovf_a), 16'h0000);
        ready_a = 1'b1;
        repeat (16) @(negedge clk);
        compare_queue(0, "ovf_drain");
        check("ovf_empty", 16'(valid_a), 16'h0000);

        // reset in the 4th data bit of 0xFF
        rxd_a = 1'b0;
        repeat (32) @(negedge clk);
        rxd_a = 1'b1;
        repeat (3 * 32 + 16) @(negedge clk);
        check("mid_busy", 16'(busy_a), 16'h0001);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_reset", 16'({valid_a, ovf_a, busy_a}), 16'h0000);
        rst = 1'b0;
        repeat (6 * 32) @(negedge clk);
        check("mid_idle", 16'(busy_a), 16'h0000);
        send(0, 9'h055, 8, 0, 1'b0, 1'b1);
        exp_a.push_back(model(9'h055, 8, 0, 1'b0, 1'b1));
        repeat (64) @(negedge clk);
        compare_queue(0, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
